// File: rtl/sprite_draw_scheduler.sv
`default_nettype none
// ============================================================================
// Module      : sprite_draw_scheduler
// Description : Round-robin scheduler that rasterises fixed-size solid
//               sprites for up to N_CH channels. Each redraw request sets a
//               pending bit. The next pending channel after the last one
//               served is granted, its position and colour are snapshotted,
//               and SPR_W*SPR_H pixels are streamed row-major over a
//               valid/ready port.
// Revision    : 1.0 - initial release
// ============================================================================
module sprite_draw_scheduler #(
  parameter int N_CH  = 6,
  parameter int SPR_W = 8,
  parameter int SPR_H = 5,
  parameter int XY_W  = 8,
  parameter int COL_W = 9
) (
  input  logic                      clk,
  input  logic                      resetn,
  input  logic [N_CH-1:0]           ch_dirty,
  input  logic                      refresh_all,
  input  logic [N_CH*XY_W-1:0]      ch_x_base,
  input  logic [N_CH*XY_W-1:0]      ch_y_base,
  input  logic [N_CH*COL_W-1:0]     ch_colour,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [XY_W-1:0]           x_out,
  output logic [XY_W-1:0]           y_out,
  output logic [COL_W-1:0]          colour_out,
  output logic [$clog2(N_CH)-1:0]   cur_ch,
  output logic                      draw_done,
  output logic                      busy
);

  localparam int CH_W = $clog2(N_CH);
  localparam int CW   = (SPR_W > 1) ? $clog2(SPR_W) : 1;
  localparam int RW   = (SPR_H > 1) ? $clog2(SPR_H) : 1;

  localparam logic [CW-1:0]   c_COL_LAST = CW'(SPR_W - 1);
  localparam logic [RW-1:0]   c_ROW_LAST = RW'(SPR_H - 1);
  localparam logic [CH_W-1:0] c_CH_LAST  = CH_W'(N_CH - 1);

  localparam logic [0:0] S_IDLE = 1'b0;
  localparam logic [0:0] S_DRAW = 1'b1;

  logic [0:0]       r_state;
  logic [N_CH-1:0]  r_pending;
  logic [CH_W-1:0]  r_last_ch;
  logic [CW-1:0]    r_col;
  logic [RW-1:0]    r_row;
  logic [XY_W-1:0]  r_x_snap;
  logic [XY_W-1:0]  r_y_snap;

  logic             w_found;
  logic [CH_W-1:0]  w_grant_ch;
  logic             w_grant;
  logic [N_CH-1:0]  w_clr;
  logic [XY_W-1:0]  w_x_sel;
  logic [XY_W-1:0]  w_y_sel;
  logic [COL_W-1:0] w_c_sel;

  // Search for the first pending channel starting just after the last one served.
  always_comb begin : p_search
    int idx;
    w_found    = 1'b0;
    w_grant_ch = '0;
    idx        = 0;
    for (int k = 1; k <= N_CH; k++) begin
      idx = int'(r_last_ch) + k;
      if (idx >= N_CH) idx = idx - N_CH;
      if (!w_found && r_pending[idx]) begin
        w_found    = 1'b1;
        w_grant_ch = CH_W'(idx);
      end
    end
  end

  assign w_grant = (r_state == S_IDLE) && w_found;

  // One-hot mask of the channel being granted this cycle.
  always_comb begin
    w_clr = '0;
    if (w_grant) w_clr[w_grant_ch] = 1'b1;
  end

  assign w_x_sel = ch_x_base[int'(w_grant_ch)*XY_W +: XY_W];
  assign w_y_sel = ch_y_base[int'(w_grant_ch)*XY_W +: XY_W];
  assign w_c_sel = ch_colour[int'(w_grant_ch)*COL_W +: COL_W];

  assign out_valid = (r_state == S_DRAW);
  assign busy      = (r_state == S_DRAW);

  // Pending bits: a request arriving on the grant cycle survives the clear.
  always_ff @(posedge clk) begin
    if (!resetn) r_pending <= '0;
    else         r_pending <= (r_pending & ~w_clr) | ch_dirty | {N_CH{refresh_all}};
  end

  // Grant/draw state machine with registered pixel outputs.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      r_state    <= S_IDLE;
      r_last_ch  <= c_CH_LAST;
      r_col      <= '0;
      r_row      <= '0;
      r_x_snap   <= '0;
      r_y_snap   <= '0;
      x_out      <= '0;
      y_out      <= '0;
      colour_out <= '0;
      cur_ch     <= '0;
      draw_done  <= 1'b0;
    end else begin
      draw_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_found) begin
            r_state    <= S_DRAW;
            r_col      <= '0;
            r_row      <= '0;
            cur_ch     <= w_grant_ch;
            r_last_ch  <= w_grant_ch;
            r_x_snap   <= w_x_sel;
            r_y_snap   <= w_y_sel;
            x_out      <= w_x_sel;
            y_out      <= w_y_sel;
            colour_out <= w_c_sel;
          end
        end
        S_DRAW: begin
          if (out_ready) begin
            if (r_col == c_COL_LAST && r_row == c_ROW_LAST) begin
              // Last pixel accepted: outputs keep their final values in IDLE.
              r_state   <= S_IDLE;
              r_col     <= '0;
              r_row     <= '0;
              draw_done <= 1'b1;
            end else if (r_col == c_COL_LAST) begin
              r_col <= '0;
              r_row <= r_row + RW'(1);
              x_out <= r_x_snap;
              y_out <= r_y_snap + XY_W'(r_row + RW'(1));
            end else begin
              r_col <= r_col + CW'(1);
              x_out <= r_x_snap + XY_W'(r_col + CW'(1));
            end
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_sprite_draw_scheduler.sv
`default_nettype none
// ============================================================================
// Module      : tb_sprite_draw_scheduler
// Description : Scoreboard bench for sprite_draw_scheduler. Stimulus queues
//               the expected pixel stream; a negedge monitor pops and
//               compares every accepted pixel and watches stalls and gaps.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_sprite_draw_scheduler;

  localparam int N_CH  = 6;
  localparam int SPR_W = 8;
  localparam int SPR_H = 5;
  localparam int XY_W  = 8;
  localparam int COL_W = 9;

  typedef struct packed {
    logic [7:0] x;
    logic [7:0] y;
    logic [8:0] c;
    logic [2:0] ch;
  } pix_t;

  logic                    clk;
  logic                    resetn;
  logic [N_CH-1:0]         ch_dirty;
  logic                    refresh_all;
  logic [N_CH*XY_W-1:0]    ch_x_base;
  logic [N_CH*XY_W-1:0]    ch_y_base;
  logic [N_CH*COL_W-1:0]   ch_colour;
  logic                    out_valid;
  logic                    out_ready;
  logic [XY_W-1:0]         x_out;
  logic [XY_W-1:0]         y_out;
  logic [COL_W-1:0]        colour_out;
  logic [2:0]              cur_ch;
  logic                    draw_done;
  logic                    busy;

  sprite_draw_scheduler #(
    .N_CH(N_CH), .SPR_W(SPR_W), .SPR_H(SPR_H), .XY_W(XY_W), .COL_W(COL_W)
  ) dut (
    .clk(clk), .resetn(resetn), .ch_dirty(ch_dirty), .refresh_all(refresh_all),
    .ch_x_base(ch_x_base), .ch_y_base(ch_y_base), .ch_colour(ch_colour),
    .out_valid(out_valid), .out_ready(out_ready), .x_out(x_out), .y_out(y_out),
    .colour_out(colour_out), .cur_ch(cur_ch), .draw_done(draw_done), .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  pix_t       exp_q[$];
  logic [7:0] xb[N_CH];
  logic [7:0] yb[N_CH];
  logic [8:0] cb[N_CH];

  int   cyc       = 0;
  int   done_cnt  = 0;
  int   xfer_cnt  = 0;
  int   gap_ok    = 0;
  int   last_done = -10;
  logic prev_valid = 1'b0;
  logic stall_prev = 1'b0;
  pix_t held;
  pix_t m_e;
  pix_t m_got;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h (t=%0t)", name, act, req, $time);
    end
  endtask

  // Monitor: sample away from the active edge and score every accepted pixel.
  always @(negedge clk) begin
    cyc++;
    if (resetn) begin
      m_got = {x_out, y_out, colour_out, cur_ch};
      if (stall_prev) begin
        check("stall_valid", 32'(out_valid), 32'd1);
        check("stall_hold", 32'(m_got), 32'(held));
      end
      if (draw_done) begin
        done_cnt++;
        last_done = cyc;
        check("done_valid_low", 32'(out_valid), 32'd0);
      end
      if (out_valid && !prev_valid && last_done == cyc - 1) gap_ok++;
      if (out_valid && out_ready) begin
        xfer_cnt++;
        if (exp_q.size() == 0) begin
          check("unexpected_pixel", 32'(m_got), 32'd0);
          if (m_got == '0) check("unexpected_pixel", 32'd1, 32'd0);
        end else begin
          m_e = exp_q.pop_front();
          check("pixel", 32'(m_got), 32'(m_e));
        end
      end
      stall_prev = out_valid && !out_ready;
      held       = m_got;
      prev_valid = out_valid;
    end else begin
      stall_prev = 1'b0;
      prev_valid = 1'b0;
    end
  end

  task automatic set_ch(input int ch, input logic [7:0] x, input logic [7:0] y, input logic [8:0] c);
    xb[ch] = x;
    yb[ch] = y;
    cb[ch] = c;
    ch_x_base[ch*XY_W +: XY_W]   = x;
    ch_y_base[ch*XY_W +: XY_W]   = y;
    ch_colour[ch*COL_W +: COL_W] = c;
  endtask

  task automatic push_sprite(input int ch);
    pix_t p;
    for (int r = 0; r < SPR_H; r++) begin
      for (int c = 0; c < SPR_W; c++) begin
        p.x  = xb[ch] + 8'(c);
        p.y  = yb[ch] + 8'(r);
        p.c  = cb[ch];
        p.ch = 3'(ch);
        exp_q.push_back(p);
      end
    end
  endtask

  task automatic pulse(input logic [N_CH-1:0] m);
    @(posedge clk); #1 ch_dirty = m;
    @(posedge clk); #1 ch_dirty = '0;
  endtask

  task automatic wait_done(input int target, input int budget);
    for (int i = 0; i < budget && done_cnt < target; i++) @(posedge clk);
    #1;
    check("draw_done_count", 32'(done_cnt), 32'(target));
    repeat (2) @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    @(posedge clk); #1 resetn = 1'b0;
    @(posedge clk); #1 resetn = 1'b1;
  endtask

  int d0;
  int g0;
  int x0;

  initial begin
    resetn      = 1'b0;
    ch_dirty    = '0;
    refresh_all = 1'b0;
    out_ready   = 1'b1;
    ch_x_base   = '0;
    ch_y_base   = '0;
    ch_colour   = '0;
    for (int i = 0; i < N_CH; i++) set_ch(i, 8'd0, 8'd0, 9'd0);
    repeat (2) @(posedge clk);
    #1 resetn = 1'b1;

    // Reset state
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_draw_done", 32'(draw_done), 32'd0);
    check("rst_x_out", 32'(x_out), 32'd0);
    check("rst_y_out", 32'(y_out), 32'd0);
    check("rst_colour", 32'(colour_out), 32'd0);
    check("rst_cur_ch", 32'(cur_ch), 32'd0);

    // Single sprite on channel 0 with latency check
    set_ch(0, 8'd10, 8'd20, 9'h1C0);
    push_sprite(0);
    d0 = done_cnt;
    pulse(6'b000001);
    check("latency_pre", 32'(out_valid), 32'd0);
    @(posedge clk); #1;
    check("latency_first", 32'(out_valid), 32'd1);
    check("busy_draw", 32'(busy), 32'd1);
    wait_done(d0 + 1, 200);
    check("busy_after", 32'(busy), 32'd0);
    check("q_empty_single", 32'(exp_q.size()), 32'd0);

    // refresh_all after reset: channels 0..5 in order, one idle cycle between
    do_reset();
    for (int i = 0; i < N_CH; i++) set_ch(i, 8'(30 * i), 8'(5 * i + 1), 9'(9'h010 + i));
    for (int i = 0; i < N_CH; i++) push_sprite(i);
    d0 = done_cnt;
    g0 = gap_ok;
    @(posedge clk); #1 refresh_all = 1'b1;
    @(posedge clk); #1 refresh_all = 1'b0;
    wait_done(d0 + 6, 800);
    check("refresh_gaps", 32'(gap_ok - g0), 32'd5);
    check("q_empty_refresh", 32'(exp_q.size()), 32'd0);

    // Round-robin from last_ch=2 and request re-arm on the grant cycle
    do_reset();
    push_sprite(2);
    d0 = done_cnt;
    pulse(6'b000100);
    wait_done(d0 + 1, 200);
    push_sprite(3);
    push_sprite(1);
    push_sprite(3);
    d0 = done_cnt;
    @(posedge clk); #1 ch_dirty = 6'b001010;
    @(posedge clk); #1 ch_dirty = 6'b001000;
    @(posedge clk); #1 ch_dirty = '0;
    wait_done(d0 + 3, 600);
    check("q_empty_rr", 32'(exp_q.size()), 32'd0);

    // Backpressure toggling; base change mid-sprite must not leak in
    set_ch(4, 8'd100, 8'd50, 9'h0AA);
    push_sprite(4);
    d0 = done_cnt;
    pulse(6'b010000);
    for (int i = 0; i < 300 && done_cnt < d0 + 1; i++) begin
      @(posedge clk); #1 out_ready = ~out_ready;
      if (i == 5) ch_x_base[4*XY_W +: XY_W] = 8'd7;
    end
    out_ready = 1'b1;
    wait_done(d0 + 1, 10);
    check("q_empty_stall", 32'(exp_q.size()), 32'd0);

    // Coordinate wraparound; outputs hold last pixel in IDLE
    set_ch(5, 8'd252, 8'd254, 9'h1FF);
    push_sprite(5);
    d0 = done_cnt;
    pulse(6'b100000);
    wait_done(d0 + 1, 200);
    check("idle_hold_x", 32'(x_out), 32'd3);
    check("idle_hold_y", 32'(y_out), 32'd2);
    check("idle_valid", 32'(out_valid), 32'd0);

    // Reset in the middle of a sprite
    set_ch(0, 8'd40, 8'd60, 9'h055);
    push_sprite(0);
    x0 = xfer_cnt;
    d0 = done_cnt;
    pulse(6'b000001);
    for (int i = 0; i < 100 && xfer_cnt < x0 + 16; i++) begin
      @(posedge clk); #1;
    end
    resetn = 1'b0;
    @(posedge clk); #1 resetn = 1'b1;
    check("abort_valid", 32'(out_valid), 32'd0);
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_x_out", 32'(x_out), 32'd0);
    repeat (10) @(posedge clk);
    #1;
    check("abort_no_done", 32'(done_cnt), 32'(d0));
    check("abort_xfers", 32'(xfer_cnt), 32'(x0 + 16));
    check("abort_remaining", 32'(exp_q.size()), 32'd24);
    exp_q.delete();
    set_ch(0, 8'd10, 8'd20, 9'h1C0);
    push_sprite(0);
    pulse(6'b000001);
    wait_done(d0 + 1, 200);
    check("q_empty_after_abort", 32'(exp_q.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
